ingress_redirect_ctrl: RTL and testbench

INGRESS_REDIRECT_CTRL -- requirements
Module: ingress_redirect_ctrl

---
 rtl/config_pkg.sv | 9 +
 rtl/ingress_ctrl_pkg.sv | 16 +
 rtl/epoch_slot_filter.sv | 30 +++
 rtl/ingress_redirect_ctrl.sv | 104 ++++++++++
 tb/tb_ingress_redirect_ctrl.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/config_pkg.sv
// Core configuration record shared by front-end blocks.
package config_pkg;
  typedef struct packed {
    int unsigned INSTR_PER_FETCH;
    int unsigned PLEN;
  } cfg_t;

  localparam cfg_t EmptyCfg = '{INSTR_PER_FETCH: 32'd4, PLEN: 32'd32};
endpackage

// File: rtl/ingress_ctrl_pkg.sv
// Shared epoch width and redirect FSM state type for fetch, backend and ingress.
package ingress_ctrl_pkg;
  localparam int unsigned EPOCH_W = 3;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2
  } ingress_ctrl_state_e;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction
endpackage

// File: rtl/epoch_slot_filter.sv
// Per-slot epoch match plus stale/valid slot counts for one fetch packet.
module epoch_slot_filter
  import ingress_ctrl_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned CW = $clog2(N + 1)
) (
  input  logic [N-1:0]              slot_valid_i,
  input  logic [N-1:0][EPOCH_W-1:0] slot_epoch_i,
  input  logic [EPOCH_W-1:0]        epoch_i,
  output logic [N-1:0]              match_o,
  output logic                      any_match_o,
  output logic [CW-1:0]             stale_cnt_o,
  output logic [CW-1:0]             valid_cnt_o
);
  for (genvar i = 0; i < N; i++) begin : g_slot
    assign match_o[i] = slot_valid_i[i] & (slot_epoch_i[i] == epoch_i);
  end

  assign any_match_o = |match_o;

  always_comb begin
    stale_cnt_o = '0;
    valid_cnt_o = '0;
    for (int i = 0; i < N; i++) begin
      stale_cnt_o = stale_cnt_o + CW'(slot_valid_i[i] & ~match_o[i]);
      valid_cnt_o = valid_cnt_o + CW'(slot_valid_i[i]);
    end
  end
endmodule

// File: rtl/ingress_redirect_ctrl.sv
// Redirect/flush sequencer: bumps the fetch epoch on redirect and filters
// stale-epoch slots between fetch and the ingress cluster without buffering.
module ingress_redirect_ctrl
  import ingress_ctrl_pkg::*;
#(
  parameter config_pkg::cfg_t Cfg           = config_pkg::EmptyCfg,
  parameter int unsigned      DRAIN_TIMEOUT = 32,
  localparam int unsigned     N             = Cfg.INSTR_PER_FETCH,
  localparam int unsigned     PLEN          = Cfg.PLEN
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      redirect_i,
  input  logic [PLEN-1:0]           redirect_pc_i,
  input  logic                      fe_valid_i,
  output logic                      fe_ready_o,
  input  logic [N-1:0]              fe_slot_valid_i,
  input  logic [N-1:0][EPOCH_W-1:0] fe_fetch_epoch_i,
  output logic                      ing_valid_o,
  input  logic                      ing_ready_i,
  output logic [N-1:0]              ing_slot_valid_o,
  output logic                      ing_flush_o,
  output logic [EPOCH_W-1:0]        epoch_o,
  output logic                      fetch_redirect_valid_o,
  output logic [PLEN-1:0]           fetch_redirect_pc_o,
  output logic                      drain_busy_o,
  output logic [15:0]               stale_drop_cnt_o
);
  localparam int unsigned CW = $clog2(N + 1);

  ingress_ctrl_state_e state_q, state_d;
  logic [EPOCH_W-1:0]  epoch_q, epoch_d;
  logic [PLEN-1:0]     pc_q, pc_d;
  logic [7:0]          drain_q, drain_d;
  logic [15:0]         stale_q, stale_d;

  logic          any_match, accept, in_flush;
  logic [CW-1:0] stale_cnt, valid_cnt, drop_cnt;

  epoch_slot_filter #(.N(N)) u_filter (
    .slot_valid_i (fe_slot_valid_i),
    .slot_epoch_i (fe_fetch_epoch_i),
    .epoch_i      (epoch_q),
    .match_o      (ing_slot_valid_o),
    .any_match_o  (any_match),
    .stale_cnt_o  (stale_cnt),
    .valid_cnt_o  (valid_cnt)
  );

  assign in_flush    = (state_q == ST_FLUSH);
  // All-stale packets are consumed immediately so fetch never stalls on them.
  assign fe_ready_o  = in_flush | ~any_match | ing_ready_i;
  assign ing_valid_o = ~in_flush & fe_valid_i & any_match;
  assign accept      = fe_valid_i & fe_ready_o;
  assign drop_cnt    = in_flush ? valid_cnt : stale_cnt;

  always_comb begin
    state_d = state_q;
    epoch_d = epoch_q;
    pc_d    = pc_q;
    drain_d = drain_q;
    stale_d = accept ? sat_add16(stale_q, 16'(drop_cnt)) : stale_q;
    if (redirect_i) begin
      state_d = ST_FLUSH;
      epoch_d = epoch_q + EPOCH_W'(1);
      pc_d    = redirect_pc_i;
    end else begin
      case (state_q)
        ST_FLUSH: begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end
        ST_DRAIN: begin
          if ((accept & any_match) || (drain_q == 8'(DRAIN_TIMEOUT - 1))) state_d = ST_RUN;
          else drain_d = drain_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_RUN;
      epoch_q <= '0;
      pc_q    <= '0;
      drain_q <= '0;
      stale_q <= '0;
    end else begin
      state_q <= state_d;
      epoch_q <= epoch_d;
      pc_q    <= pc_d;
      drain_q <= drain_d;
      stale_q <= stale_d;
    end
  end

  assign ing_flush_o            = in_flush;
  assign fetch_redirect_valid_o = in_flush;
  assign fetch_redirect_pc_o    = pc_q;
  assign epoch_o                = epoch_q;
  assign drain_busy_o           = (state_q != ST_RUN);
  assign stale_drop_cnt_o       = stale_q;
endmodule

// File: tb/tb_ingress_redirect_ctrl.sv
// Randomized bench for ingress_redirect_ctrl against a cycle-level behavioural model.
module tb_ingress_redirect_ctrl;
  localparam int N  = 4;
  localparam int TO = 12;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              redirect;
  logic [31:0]       rpc;
  logic              fe_valid, fe_ready;
  logic [N-1:0]      fe_sv;
  logic [N-1:0][2:0] fe_ep;
  logic              ing_valid, ing_ready;
  logic [N-1:0]      ing_sv;
  logic              ing_flush, fr_valid, busy;
  logic [2:0]        epoch;
  logic [31:0]       fr_pc;
  logic [15:0]       cnt;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  ingress_redirect_ctrl #(.DRAIN_TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .redirect_i(redirect), .redirect_pc_i(rpc),
    .fe_valid_i(fe_valid), .fe_ready_o(fe_ready), .fe_slot_valid_i(fe_sv),
    .fe_fetch_epoch_i(fe_ep), .ing_valid_o(ing_valid), .ing_ready_i(ing_ready),
    .ing_slot_valid_o(ing_sv), .ing_flush_o(ing_flush), .epoch_o(epoch),
    .fetch_redirect_valid_o(fr_valid), .fetch_redirect_pc_o(fr_pc),
    .drain_busy_o(busy), .stale_drop_cnt_o(cnt)
  );

  always #5 clk = ~clk;

  // Model: mode 0=running, 1=flushing, 2=draining.
  int         m_mode = 0;
  logic [2:0] m_epoch = '0;
  logic [31:0] m_pc = '0;
  int         m_cnt = 0;
  int         m_drain_start = 0;
  int         cyc = 0;

  function automatic logic [N-1:0] f_match();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = fe_sv[i] && (fe_ep[i] == m_epoch);
    return r;
  endfunction

  function automatic logic f_ready();
    return (m_mode == 1) || (f_match() == '0) || ing_ready;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_mode = 0; m_epoch = '0; m_pc = '0; m_cnt = 0;
    end else begin
      logic [N-1:0] mt;
      logic acc;
      int d;
      mt  = f_match();
      acc = fe_valid && f_ready();
      if (acc) begin
        d = (m_mode == 1) ? $countones(fe_sv) : $countones(fe_sv & ~mt);
        m_cnt = (m_cnt + d > 65535) ? 65535 : m_cnt + d;
      end
      if (redirect) begin
        m_mode = 1; m_epoch = m_epoch + 3'd1; m_pc = rpc;
      end else if (m_mode == 1) begin
        m_mode = 2; m_drain_start = cyc + 1;
      end else if (m_mode == 2 && ((acc && mt != '0) || (cyc - m_drain_start == TO - 1))) begin
        m_mode = 0;
      end
      cyc++;
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      logic [N-1:0] mt;
      mt = f_match();
      chk("ing_slot_valid", 32'(ing_sv), 32'(mt));
      chk("ing_valid", 32'(ing_valid), 32'((m_mode != 1) && fe_valid && (mt != '0)));
      chk("fe_ready", 32'(fe_ready), 32'(f_ready()));
      chk("ing_flush", 32'(ing_flush), 32'(m_mode == 1));
      chk("redirect_valid", 32'(fr_valid), 32'(m_mode == 1));
      chk("redirect_pc", fr_pc, m_pc);
      chk("epoch", 32'(epoch), 32'(m_epoch));
      chk("drain_busy", 32'(busy), 32'(m_mode != 0));
      chk("stale_cnt", 32'(cnt), 32'(m_cnt));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    fe_valid = 1'b0; fe_sv = '0; fe_ep = '0; redirect = 1'b0; ing_ready = 1'b1;
  endtask

  initial begin
    idle(); rpc = '0;
    repeat (3) @(posedge clk);
    #1 chk_en = 1'b1;
    #1;
    chk("rst_epoch", 32'(epoch), 0);
    chk("rst_flush", 32'(ing_flush), 0);
    chk("rst_rvalid", 32'(fr_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pc", fr_pc, 0);
    chk("rst_cnt", 32'(cnt), 0);
    rst_n = 1'b1;

    // First packet after reset, all slots epoch 0
    fe_valid = 1'b1; fe_sv = 4'hF; fe_ep = '0; ing_ready = 1'b1; #1;
    chk("pass_valid", 32'(ing_valid), 1);
    chk("pass_slots", 32'(ing_sv), 32'hF);
    chk("pass_cnt", 32'(cnt), 0);
    tick(); idle(); redirect = 1'b1; rpc = 32'h8000_0100;
    tick(); redirect = 1'b0; #1;
    chk("rd_flush", 32'(ing_flush), 1);
    chk("rd_rvalid", 32'(fr_valid), 1);
    chk("rd_pc", fr_pc, 32'h8000_0100);
    chk("rd_epoch", 32'(epoch), 1);
    tick(); #1;
    chk("rd_drain_busy", 32'(busy), 1);
    chk("rd_flush_off", 32'(ing_flush), 0);

    // Stale packet in drain, then a matching one
    fe_valid = 1'b1; fe_sv = 4'hF; fe_ep = '0; #1;
    chk("drain_ready", 32'(fe_ready), 1);
    chk("drain_ivalid", 32'(ing_valid), 0);
    tick(); #1;
    chk("drain_cnt", 32'(cnt), 4);
    chk("drain_still", 32'(busy), 1);
    fe_ep = {3'd1, 3'd1, 3'd1, 3'd1}; #1;
    chk("drain_fwd", 32'(ing_valid), 1);
    tick(); idle(); #1;
    chk("drain_exit", 32'(busy), 0);

    // Mixed epochs {1,0,1,0} with backpressure
    fe_valid = 1'b1; fe_sv = 4'hF; ing_ready = 1'b0;
    fe_ep = {3'd0, 3'd1, 3'd0, 3'd1}; #1;
    chk("mix_slots", 32'(ing_sv), 32'b0101);
    chk("mix_ready", 32'(fe_ready), 0);
    tick(); #1;
    chk("mix_hold_cnt", 32'(cnt), 4);
    ing_ready = 1'b1;
    tick(); idle(); #1;
    chk("mix_cnt", 32'(cnt), 6);

    // Back-to-back to epoch 7, then eight spaced redirects wrapping round
    redirect = 1'b1;
    repeat (6) tick();
    redirect = 1'b0; #1;
    chk("b2b_epoch", 32'(epoch), 7);
    chk("b2b_flush", 32'(ing_flush), 1);
    tick();
    for (int k = 0; k < 8; k++) begin
      redirect = 1'b1; rpc = 32'(k * 4);
      tick(); redirect = 1'b0; #1;
      chk("wrap_epoch", 32'(epoch), 32'(k));
      chk("wrap_flush", 32'(ing_flush), 1);
      chk("wrap_pc", fr_pc, 32'(k * 4));
      tick(); #1;
      chk("wrap_flush_off", 32'(ing_flush), 0);
    end

    // Idle drain must time out exactly TO cycles after entry
    for (int k = 1; k <= TO; k++) begin
      tick(); #1;
      chk("timeout_busy", 32'(busy), 32'(k < TO));
    end

    // Randomized traffic with occasional async reset
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
      redirect  = ($urandom_range(0, 7) == 0);
      rpc       = $urandom;
      fe_valid  = ($urandom_range(0, 99) < ((c % 600) < 300 ? 70 : 5));
      fe_sv     = N'($urandom);
      ing_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) fe_ep[i] = $urandom_range(0, 1) ? m_epoch : 3'($urandom);
    end

    // Saturation of the stale-drop counter
    tick(); idle(); rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    fe_valid = 1'b1; fe_sv = 4'hF; fe_ep = {3'd1, 3'd1, 3'd1, 3'd1};
    repeat (16400) tick();
    #1 chk("sat_cnt", 32'(cnt), 32'hFFFF);
    idle();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
